// File: rtl/ck_rst_pkg.sv
// Shared encodings and defaults for the clock-enable / reset sequencer.
package ck_rst_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  localparam int unsigned DefNCh         = 4;
  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefHoldCycles  = 16;
  localparam int unsigned DefGapCycles   = 4;
  localparam int unsigned DefDiv         = 10;

  // Counter width for a counter that runs 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/ck_rst_seq_if.sv
// Software-reset handshake and sequenced reset / tick outputs of ck_rst_seq.
interface ck_rst_seq_if #(
  parameter int unsigned N_CH = 4
) ();

  logic            sw_rst_req;
  logic            sw_rst_ack;
  logic [N_CH-1:0] rst_n_out;
  logic            ready;
  logic            tick;

  modport master (
    input  sw_rst_req,
    output sw_rst_ack,
    output rst_n_out,
    output ready,
    output tick
  );

  modport slave (
    output sw_rst_req,
    input  sw_rst_ack,
    input  rst_n_out,
    input  ready,
    input  tick
  );

endinterface

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES rising edges.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ck_rst_seq.sv
// Multi-channel reset sequencer: hold, ordered per-channel release, then a
// periodic clock-enable tick; a software request restarts the sequence.
module ck_rst_seq
  import ck_rst_pkg::*;
#(
  parameter int unsigned N_CH        = DefNCh,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned GAP_CYCLES  = DefGapCycles,
  parameter int unsigned DIV         = DefDiv
) (
  input  logic          clk,
  input  logic          rst_n,
  ck_rst_seq_if.master  bus
);

  localparam int unsigned CntLim = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = cnt_width(CntLim);
  localparam int unsigned IdxW   = cnt_width(N_CH);
  localparam int unsigned TickW  = cnt_width(DIV);
  localparam logic [N_CH-1:0] ChOne = N_CH'(1);

  logic rst_n_sync;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TickW-1:0] tcnt_q, tcnt_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic             ready_q, ready_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    out_d   = out_q;
    ready_d = ready_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;

    if (rst_n_sync) begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            state_d = StRelease;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = out_q | ChOne;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          // idx_q is the channel released most recently.
          if (idx_q == IdxW'(N_CH - 1)) begin
            state_d = StRun;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            out_d = out_q | (ChOne << idx_d);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (tcnt_q == TickW'(DIV - 1)) begin
            tcnt_d = '0;
            tick_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = StAssert;
      endcase

      // A request during ASSERT is dropped; otherwise it restarts the sequence.
      if (bus.sw_rst_req && (state_q != StAssert)) begin
        state_d = StAssert;
        cnt_d   = '0;
        idx_d   = '0;
        tcnt_d  = '0;
        out_d   = '0;
        ready_d = 1'b0;
        tick_d  = 1'b0;
        ack_d   = 1'b1;
      end
    end
  end

  assign bus.rst_n_out  = out_q;
  assign bus.ready      = ready_q;
  assign bus.tick       = tick_q;
  assign bus.sw_rst_ack = ack_q;

endmodule

// File: tb/tb_ck_rst_seq.sv
// Scoreboard bench for ck_rst_seq: expected output changes are queued by edge
// number; a monitor compares each observed output change against the queue.
module tb_ck_rst_seq;

  typedef struct packed {
    logic [3:0] out;
    logic       rdy;
    logic       tck;
    logic       ack;
  } snap_t;

  typedef struct {
    int    at;
    snap_t s;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_n_b;
  int   ecnt;
  int   base_a;
  int   base_b;
  int   frc_a;
  int   frc_b;
  bit   done;
  event chk_ev;

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp;
  int n_bad;

  ck_rst_seq_if #(.N_CH(4)) a_if ();
  ck_rst_seq_if #(.N_CH(1)) b_if ();

  ck_rst_seq u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.master)
  );

  ck_rst_seq #(
    .N_CH        (1),
    .SYNC_STAGES (2),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1),
    .DIV         (2)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (b_if.master)
  );

  // Edge counter is bumped just before each rising edge.
  initial begin
    clk  = 1'b0;
    ecnt = 0;
    forever begin
      #5;
      ecnt++;
      clk = 1'b1;
      #5;
      clk = 1'b0;
    end
  end

  task automatic ea(input int rel, input logic [3:0] o, input logic r, input logic t,
                    input logic k);
    exp_t e;
    e.at    = base_a + rel;
    e.s.out = o;
    e.s.rdy = r;
    e.s.tck = t;
    e.s.ack = k;
    qa.push_back(e);
  endtask

  task automatic eb(input int rel, input logic o, input logic r, input logic t);
    exp_t e;
    e.at    = base_b + rel;
    e.s.out = {3'b000, o};
    e.s.rdy = r;
    e.s.tck = t;
    e.s.ack = 1'b0;
    qb.push_back(e);
  endtask

  task automatic wait_abs(input int target);
    while (ecnt < target) @(posedge clk);
    #1;
  endtask

  task automatic push_zero_a();
    exp_t e;
    e.at = ecnt;
    e.s  = '0;
    qa.push_back(e);
    frc_a++;
  endtask

  task automatic push_zero_b();
    exp_t e;
    e.at = ecnt;
    e.s  = '0;
    qb.push_back(e);
    frc_b++;
  endtask

  // rst_n low for 3 ns between edges; the next rising edge is relative edge 1.
  task automatic pulse_a();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push_zero_a();
    ->chk_ev;
    #2 rst_n = 1'b1;
    base_a = ecnt;
  endtask

  task automatic release_events_a();
    ea(18, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(22, 4'b0011, 1'b0, 1'b0, 1'b0);
    ea(26, 4'b0111, 1'b0, 1'b0, 1'b0);
    ea(30, 4'b1111, 1'b0, 1'b0, 1'b0);
    ea(31, 4'b1111, 1'b1, 1'b0, 1'b0);
  endtask

  // Stimulus.
  initial begin
    rst_n           = 1'b1;
    rst_n_b         = 1'b1;
    a_if.sw_rst_req = 1'b0;
    b_if.sw_rst_req = 1'b0;
    base_a = 0;
    base_b = 0;
    frc_a  = 0;
    frc_b  = 0;
    done   = 1'b0;

    #1 rst_n = 1'b0;
    rst_n_b  = 1'b0;
    #1;
    push_zero_a();
    push_zero_b();
    ->chk_ev;

    // Power-up: low for three edges, released before relative edge 1.
    wait_abs(3);
    @(negedge clk);
    #2 rst_n = 1'b1;
    base_a = ecnt;
    release_events_a();
    ea(41, 4'b1111, 1'b1, 1'b1, 1'b0);
    ea(42, 4'b1111, 1'b1, 1'b0, 1'b0);
    ea(51, 4'b1111, 1'b1, 1'b1, 1'b0);
    ea(52, 4'b1111, 1'b1, 1'b0, 1'b0);
    wait_abs(base_a + 53);

    // Asynchronous reset in RUN, replay, then software reset in RUN at edge 40.
    pulse_a();
    release_events_a();
    ea(40, 4'b0000, 1'b0, 1'b0, 1'b1);
    ea(41, 4'b0000, 1'b0, 1'b0, 1'b0);
    ea(56, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(60, 4'b0011, 1'b0, 1'b0, 1'b0);
    ea(64, 4'b0111, 1'b0, 1'b0, 1'b0);
    ea(68, 4'b1111, 1'b0, 1'b0, 1'b0);
    ea(69, 4'b1111, 1'b1, 1'b0, 1'b0);
    wait_abs(base_a + 39);
    a_if.sw_rst_req = 1'b1;
    wait_abs(base_a + 40);
    a_if.sw_rst_req = 1'b0;
    wait_abs(base_a + 71);

    // Software reset in RELEASE at edge 23.
    pulse_a();
    ea(18, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(22, 4'b0011, 1'b0, 1'b0, 1'b0);
    ea(23, 4'b0000, 1'b0, 1'b0, 1'b1);
    ea(24, 4'b0000, 1'b0, 1'b0, 1'b0);
    ea(39, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(43, 4'b0011, 1'b0, 1'b0, 1'b0);
    ea(47, 4'b0111, 1'b0, 1'b0, 1'b0);
    ea(51, 4'b1111, 1'b0, 1'b0, 1'b0);
    ea(52, 4'b1111, 1'b1, 1'b0, 1'b0);
    wait_abs(base_a + 22);
    a_if.sw_rst_req = 1'b1;
    wait_abs(base_a + 23);
    a_if.sw_rst_req = 1'b0;
    wait_abs(base_a + 53);

    // Request held over edges 5..20: ignored in ASSERT, taken at first RELEASE edge 19.
    pulse_a();
    ea(18, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(19, 4'b0000, 1'b0, 1'b0, 1'b1);
    ea(20, 4'b0000, 1'b0, 1'b0, 1'b0);
    ea(35, 4'b0001, 1'b0, 1'b0, 1'b0);
    ea(39, 4'b0011, 1'b0, 1'b0, 1'b0);
    ea(43, 4'b0111, 1'b0, 1'b0, 1'b0);
    ea(47, 4'b1111, 1'b0, 1'b0, 1'b0);
    ea(48, 4'b1111, 1'b1, 1'b0, 1'b0);
    ea(58, 4'b1111, 1'b1, 1'b1, 1'b0);
    ea(59, 4'b1111, 1'b1, 1'b0, 1'b0);
    wait_abs(base_a + 4);
    a_if.sw_rst_req = 1'b1;
    wait_abs(base_a + 20);
    a_if.sw_rst_req = 1'b0;
    wait_abs(base_a + 60);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push_zero_a();
    ->chk_ev;

    // Minimal configuration on the second instance.
    @(negedge clk);
    #2 rst_n_b = 1'b1;
    base_b = ecnt;
    eb(3, 1'b1, 1'b0, 1'b0);
    eb(4, 1'b1, 1'b1, 1'b0);
    for (int k = 6; k <= 11; k += 2) begin
      eb(k, 1'b1, 1'b1, 1'b1);
      eb(k + 1, 1'b1, 1'b1, 1'b0);
    end
    wait_abs(base_b + 11);
    @(negedge clk);
    #1 rst_n_b = 1'b0;
    #1;
    push_zero_b();
    ->chk_ev;

    wait_abs(ecnt + 3);
    done = 1'b1;
    ->chk_ev;
  end

  task automatic cmp(input string nm, input bit have, input exp_t e, input snap_t cur);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s_unexpected: edge %0d got out=%b rdy=%b tick=%b ack=%b, want no change",
               nm, ecnt, cur.out, cur.rdy, cur.tck, cur.ack);
    end else if (e.at != ecnt || cur !== e.s) begin
      n_bad++;
      $display("FAIL %s: edge %0d got out=%b rdy=%b tick=%b ack=%b, want edge %0d out=%b rdy=%b tick=%b ack=%b",
               nm, ecnt, cur.out, cur.rdy, cur.tck, cur.ack,
               e.at, e.s.out, e.s.rdy, e.s.tck, e.s.ack);
    end
  endtask

  // Monitor: compares on every output change, or when a forced check is posted.
  initial begin : monitor
    snap_t cur_a;
    snap_t cur_b;
    snap_t prev_a;
    snap_t prev_b;
    exp_t  e;
    bit    have;
    int    seen_a;
    int    seen_b;
    n_cmp  = 0;
    n_bad  = 0;
    prev_a = '0;
    prev_b = '0;
    seen_a = 0;
    seen_b = 0;
    forever begin
      @(negedge clk or chk_ev);
      if (done) begin
        while (qa.size() > 0) begin
          e = qa.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL A_missing: got no change, want edge %0d out=%b rdy=%b tick=%b ack=%b",
                   e.at, e.s.out, e.s.rdy, e.s.tck, e.s.ack);
        end
        while (qb.size() > 0) begin
          e = qb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL B_missing: got no change, want edge %0d out=%b rdy=%b tick=%b",
                   e.at, e.s.out, e.s.rdy, e.s.tck);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      cur_a.out = a_if.rst_n_out;
      cur_a.rdy = a_if.ready;
      cur_a.tck = a_if.tick;
      cur_a.ack = a_if.sw_rst_ack;
      cur_b.out = {3'b000, b_if.rst_n_out};
      cur_b.rdy = b_if.ready;
      cur_b.tck = b_if.tick;
      cur_b.ack = b_if.sw_rst_ack;
      if (frc_a != seen_a || cur_a !== prev_a) begin
        seen_a = frc_a;
        have   = (qa.size() > 0);
        if (have) e = qa.pop_front();
        cmp("A", have, e, cur_a);
        prev_a = cur_a;
      end
      if (frc_b != seen_b || cur_b !== prev_b) begin
        seen_b = frc_b;
        have   = (qb.size() > 0);
        if (have) e = qb.pop_front();
        cmp("B", have, e, cur_b);
        prev_b = cur_b;
      end
    end
  end

  // Absolute bound on run time.
  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus, want completion before 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
